// File: rtl/keypad_lock.sv
// keypad_lock: BCD code-entry lock with retry counter, lockout and buzzer pulse.
// A one-hot keypad scan code is edge-detected so each physical press acts once.
module keypad_lock #(
  parameter int unsigned         DIGITS      = 3,
  parameter logic [DIGITS*4-1:0] CODE        = 12'h246,
  parameter int unsigned         MAX_TRIES   = 6,
  parameter int unsigned         BUZZ_CYCLES = 150000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  onehot,
  output logic [DIGITS*4-1:0]          display,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic [3:0]                   tries,
  output logic                         pass,
  output logic                         locked,
  output logic                         buzzer
);

  localparam int unsigned DW = DIGITS * 4;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned BW = $clog2(BUZZ_CYCLES + 1);

  localparam logic [1:0] S_ENTRY  = 2'd0;
  localparam logic [1:0] S_PASS   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [3:0] K_ENTER  = 4'd10;
  localparam logic [3:0] K_CLEAR  = 4'd11;
  localparam logic [3:0] K_MASTER = 4'd12;
  localparam logic [3:0] K_NONE   = 4'd15;

  localparam logic [DW-1:0] DISP_BLANK = {DIGITS{4'hF}};
  localparam logic [DW-1:0] DISP_OPEN  = {DIGITS{4'hA}};
  localparam logic [DW-1:0] DISP_LOCK  = {DIGITS{4'h0}};

  logic [15:0]   r_prev;
  logic          r_armed;
  logic [1:0]    r_state;
  logic [DW-1:0] r_display;
  logic [CW-1:0] r_count;
  logic [3:0]    r_tries;
  logic          r_pass;
  logic          r_locked;
  logic          r_buzzer;
  logic [BW-1:0] r_buzz_cnt;

  logic [3:0]    w_key;
  logic          w_press;
  logic          w_is_digit;
  logic [DW-1:0] w_shift;
  logic [3:0]    w_tries_inc;
  logic [1:0]    w_state_nxt;
  logic [DW-1:0] w_display_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [3:0]    w_tries_nxt;
  logic          w_fail;
  logic          w_master;

  // Keypad matrix bit to key value; anything not exactly one mapped bit is K_NONE.
  function automatic logic [3:0] decode_key(input logic [15:0] code);
    case (code)
      16'h0008: decode_key = 4'd0;
      16'h0080: decode_key = 4'd1;
      16'h0040: decode_key = 4'd2;
      16'h0020: decode_key = 4'd3;
      16'h0800: decode_key = 4'd4;
      16'h0400: decode_key = 4'd5;
      16'h0200: decode_key = 4'd6;
      16'h8000: decode_key = 4'd7;
      16'h4000: decode_key = 4'd8;
      16'h2000: decode_key = 4'd9;
      16'h0001: decode_key = K_ENTER;
      16'h1000: decode_key = K_CLEAR;
      16'h0100: decode_key = K_MASTER;
      default:  decode_key = K_NONE;
    endcase
  endfunction

  // r_armed stays low after reset until an idle keypad is seen, so a key
  // held through reset release cannot count as a fresh press.
  assign w_key       = decode_key(onehot);
  assign w_press     = r_armed && (r_prev == 16'h0000) && (w_key != K_NONE);
  assign w_is_digit  = (w_key <= 4'd9);
  assign w_shift     = DW'({r_display, 4'h0}) | DW'(w_key);
  assign w_tries_inc = r_tries + 4'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_display_nxt = r_display;
    w_count_nxt   = r_count;
    w_tries_nxt   = r_tries;
    w_fail        = 1'b0;
    w_master      = 1'b0;
    if (w_press) begin
      if (w_key == K_MASTER) begin
        w_state_nxt   = S_ENTRY;
        w_display_nxt = DISP_BLANK;
        w_count_nxt   = '0;
        w_tries_nxt   = 4'd0;
        w_master      = 1'b1;
      end else begin
        case (r_state)
          S_ENTRY: begin
            if (w_is_digit) begin
              if (r_count < CW'(DIGITS)) begin
                w_display_nxt = w_shift;
                w_count_nxt   = r_count + CW'(1);
              end
            end else if (w_key == K_ENTER) begin
              if (r_count == CW'(DIGITS)) begin
                w_count_nxt = '0;
                if (r_display == CODE) begin
                  w_state_nxt   = S_PASS;
                  w_display_nxt = DISP_OPEN;
                end else begin
                  w_tries_nxt   = w_tries_inc;
                  w_display_nxt = DISP_BLANK;
                  w_fail        = 1'b1;
                  if (w_tries_inc == 4'(MAX_TRIES)) begin
                    w_state_nxt   = S_LOCKED;
                    w_display_nxt = DISP_LOCK;
                  end
                end
              end
            end else if (w_key == K_CLEAR) begin
              w_display_nxt = DISP_BLANK;
              w_count_nxt   = '0;
            end
          end
          S_PASS: begin
            if (w_key == K_CLEAR) begin
              w_state_nxt   = S_ENTRY;
              w_display_nxt = DISP_BLANK;
              w_count_nxt   = '0;
            end
          end
          S_LOCKED: begin
            w_state_nxt = S_LOCKED;
          end
          default: begin
            w_state_nxt   = S_ENTRY;
            w_display_nxt = DISP_BLANK;
            w_count_nxt   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= 16'h0000;
      r_armed   <= 1'b0;
      r_state   <= S_ENTRY;
      r_display <= DISP_BLANK;
      r_count   <= '0;
      r_tries   <= 4'd0;
      r_pass    <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_prev    <= onehot;
      r_armed   <= r_armed | (onehot == 16'h0000);
      r_state   <= w_state_nxt;
      r_display <= w_display_nxt;
      r_count   <= w_count_nxt;
      r_tries   <= w_tries_nxt;
      r_pass    <= (w_state_nxt == S_PASS);
      r_locked  <= (w_state_nxt == S_LOCKED);
    end
  end

  // Buzzer pulse: counter holds the cycles left after the current one; saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buzzer   <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (w_master) begin
      r_buzzer   <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (w_fail) begin
      r_buzzer   <= 1'b1;
      r_buzz_cnt <= BW'(BUZZ_CYCLES - 1);
    end else if (r_buzzer) begin
      if (r_buzz_cnt == '0) begin
        r_buzzer <= 1'b0;
      end else begin
        r_buzz_cnt <= r_buzz_cnt - BW'(1);
      end
    end
  end

  assign display = r_display;
  assign count   = r_count;
  assign tries   = r_tries;
  assign pass    = r_pass;
  assign locked  = r_locked;
  assign buzzer  = r_buzzer;

endmodule
